oled_i2c_sequencer: RTL

OLED_I2C_SEQUENCER -- requirements
Module: oled_i2c_sequencer

---
 rtl/oled_i2c_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/oled_i2c_sequencer.sv
// OLED I2C sequencer: sends an 8-byte init command table, then streams
// pixel frames to an I2C master via separate command and write-data ports.
module oled_i2c_sequencer #(
   parameter logic [6:0] ADDRESS     = 7'h3C,
   parameter int         FRAME_BYTES = 1024,
   parameter int         INIT_LEN    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       frame_req,
   input  logic [7:0] pix_data,
   input  logic       pix_valid,
   output logic       pix_ready,
   output logic [6:0] cmd_address,
   output logic       cmd_start,
   output logic       cmd_write_multiple,
   output logic       cmd_stop,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic [7:0] data_in,
   output logic       data_in_valid,
   output logic       data_in_last,
   input  logic       data_in_ready,
   input  logic       busy,
   input  logic       missed_ack,
   output logic       init_done,
   output logic       frame_done,
   output logic       error,
   output logic       seq_busy
);

   localparam logic [3:0] IDLE   = 4'd0;
   localparam logic [3:0] I_CMD  = 4'd1;
   localparam logic [3:0] I_CTRL = 4'd2;
   localparam logic [3:0] I_DATA = 4'd3;
   localparam logic [3:0] I_WAIT = 4'd4;
   localparam logic [3:0] READY  = 4'd5;
   localparam logic [3:0] F_CMD  = 4'd6;
   localparam logic [3:0] F_CTRL = 4'd7;
   localparam logic [3:0] F_DATA = 4'd8;
   localparam logic [3:0] F_WAIT = 4'd9;
   localparam logic [3:0] ERROR  = 4'd10;

   localparam logic [10:0] INIT_LAST  = 11'(INIT_LEN - 1);
   localparam logic [10:0] FRAME_LAST = 11'(FRAME_BYTES - 1);

   localparam logic [7:0] CTRL_CMD  = 8'h00;
   localparam logic [7:0] CTRL_DATA = 8'h40;

   logic [3:0]  state;
   logic [10:0] cnt;
   logic        cmd_phase;
   logic        cmd_fire;
   logic        dat_fire;
   logic        abort;

   function automatic logic [7:0] init_byte(input logic [2:0] idx);
      logic [7:0] b;
      unique case (idx)
         3'd0:    b = 8'hAE;
         3'd1:    b = 8'h8D;
         3'd2:    b = 8'h14;
         3'd3:    b = 8'h20;
         3'd4:    b = 8'h00;
         3'd5:    b = 8'hA1;
         3'd6:    b = 8'hC8;
         default: b = 8'hAF;
      endcase
      return b;
   endfunction

   assign seq_busy  = (state != IDLE) && (state != READY) && (state != ERROR);
   assign cmd_phase = (state == I_CMD) || (state == F_CMD);

   assign cmd_valid          = cmd_phase;
   assign cmd_start          = cmd_phase;
   assign cmd_write_multiple = cmd_phase;
   assign cmd_stop           = cmd_phase;
   assign cmd_address        = cmd_phase ? ADDRESS : 7'd0;

   assign cmd_fire = cmd_valid && cmd_ready;
   assign dat_fire = data_in_valid && data_in_ready;
   // A NACK beats any handshake that completes in the same cycle.
   assign abort    = missed_ack && seq_busy;

   always_comb begin
      data_in       = 8'h00;
      data_in_valid = 1'b0;
      data_in_last  = 1'b0;
      pix_ready     = 1'b0;
      unique case (state)
         I_CTRL: begin
            data_in       = CTRL_CMD;
            data_in_valid = 1'b1;
         end
         I_DATA: begin
            data_in       = init_byte(cnt[2:0]);
            data_in_valid = 1'b1;
            data_in_last  = (cnt == INIT_LAST);
         end
         F_CTRL: begin
            data_in       = CTRL_DATA;
            data_in_valid = 1'b1;
         end
         F_DATA: begin
            data_in       = pix_data;
            data_in_valid = pix_valid;
            data_in_last  = (cnt == FRAME_LAST);
            pix_ready     = data_in_ready;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= 11'd0;
         init_done  <= 1'b0;
         frame_done <= 1'b0;
         error      <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (abort) begin
            state     <= ERROR;
            error     <= 1'b1;
            init_done <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start) state <= I_CMD;
               end
               I_CMD: begin
                  if (cmd_fire) state <= I_CTRL;
               end
               I_CTRL: begin
                  if (dat_fire) begin
                     state <= I_DATA;
                     cnt   <= 11'd0;
                  end
               end
               I_DATA: begin
                  if (dat_fire) begin
                     cnt <= cnt + 11'd1;
                     if (data_in_last) state <= I_WAIT;
                  end
               end
               I_WAIT: begin
                  if (!busy) begin
                     state     <= READY;
                     init_done <= 1'b1;
                  end
               end
               READY: begin
                  if (start) begin
                     state     <= I_CMD;
                     init_done <= 1'b0;
                  end else if (frame_req) begin
                     state <= F_CMD;
                  end
               end
               F_CMD: begin
                  if (cmd_fire) state <= F_CTRL;
               end
               F_CTRL: begin
                  if (dat_fire) begin
                     state <= F_DATA;
                     cnt   <= 11'd0;
                  end
               end
               F_DATA: begin
                  if (dat_fire) begin
                     cnt <= cnt + 11'd1;
                     if (data_in_last) state <= F_WAIT;
                  end
               end
               F_WAIT: begin
                  if (!busy) begin
                     state      <= READY;
                     frame_done <= 1'b1;
                  end
               end
               ERROR: begin
                  if (start) begin
                     state <= I_CMD;
                     error <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
